// File: rtl/qsys_led_b2p_pkg.sv
// Shared constants and decoder state encoding for the bytes-to-packets decoder.
package qsys_led_b2p_pkg;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ESC      = 2'd1,
        ST_CHAN     = 2'd2,
        ST_CHAN_ESC = 2'd3
    } dec_state_e;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= SOP_CHAR) && (b <= ESC_CHAR);
    endfunction

endpackage

// File: rtl/qsys_led_b2p_oreg.sv
// One-deep output register with Avalon-ST ready generation.
module qsys_led_b2p_oreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_payload,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] payload,
    output logic         in_ready
);

    assign in_ready = out_ready || !out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            payload   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            payload   <= load_payload;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qsys_led_master_0_b2p.sv
// Bytes-to-packets decoder: strips framing/escape bytes and emits SOP/EOP/channel beats.
// Optional protocol error tracking is enabled by defining QSYS_B2P_ERR_CHECK_EN.
module qsys_led_master_0_b2p
    import qsys_led_b2p_pkg::*;
#(
    parameter int CHANNEL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic [CHANNEL_W-1:0] out_channel,
    input  logic                 out_ready,
    output logic                 err_sticky
);

    localparam int PW = CHANNEL_W + 10;

    dec_state_e           state;
    logic                 sop_pend;
    logic                 eop_pend;
    logic [CHANNEL_W-1:0] chan_reg;
    logic                 accept;
    logic                 beat;
    logic                 chan_load;
    logic [7:0]           decoded;
    logic [PW-1:0]        payload;

    assign accept = in_valid && in_ready;

    always_comb begin
        beat      = 1'b0;
        chan_load = 1'b0;
        decoded   = in_data;
        case (state)
            ST_IDLE:     beat = !is_special(in_data);
            ST_ESC: begin
                beat    = 1'b1;
                decoded = in_data ^ ESC_XOR;
            end
            ST_CHAN:     chan_load = (in_data != ESC_CHAR);
            ST_CHAN_ESC: begin
                chan_load = 1'b1;
                decoded   = in_data ^ ESC_XOR;
            end
            default: ;
        endcase
        beat      = beat && accept;
        chan_load = chan_load && accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            sop_pend <= 1'b0;
            eop_pend <= 1'b0;
            chan_reg <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == SOP_CHAR)  sop_pend <= 1'b1;
                    if (in_data == EOP_CHAR)  eop_pend <= 1'b1;
                    if (in_data == CHAN_CHAR) state    <= ST_CHAN;
                    if (in_data == ESC_CHAR)  state    <= ST_ESC;
                end
                ST_CHAN:  state <= (in_data == ESC_CHAR) ? ST_CHAN_ESC : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (chan_load) chan_reg <= decoded[CHANNEL_W-1:0];
            // A beat only occurs on non-framing bytes, so clearing here never races a set.
            if (beat) begin
                sop_pend <= 1'b0;
                eop_pend <= 1'b0;
            end
        end
    end

    qsys_led_b2p_oreg #(.W(PW)) u_oreg (
        .clk          (clk),
        .reset        (reset),
        .load         (beat),
        .load_payload ({sop_pend, eop_pend, chan_reg, decoded}),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .payload      (payload),
        .in_ready     (in_ready)
    );

    assign out_startofpacket = payload[PW-1];
    assign out_endofpacket   = payload[PW-2];
    assign out_channel       = payload[PW-3:8];
    assign out_data          = payload[7:0];

`ifdef QSYS_B2P_ERR_CHECK_EN
    logic in_packet;
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_packet <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (beat) begin
                if (sop_pend) begin
                    if (in_packet) err_q <= 1'b1;
                    in_packet <= !eop_pend;
                end else begin
                    if (!in_packet) err_q <= 1'b1;
                    if (eop_pend) in_packet <= 1'b0;
                end
            end
            // An escape must be followed by an encoded byte, never a raw special.
            if (accept && (state == ST_ESC || state == ST_CHAN_ESC) && is_special(in_data))
                err_q <= 1'b1;
        end
    end

    assign err_sticky = err_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: doc/qsys_led_master_0_b2p.md
Name: qsys_led_master_0_b2p

Overview:
- Bytes-to-packets decoder directly downstream of the master's 8-bit Avalon-ST timing adapter.
- Consumes the escaped byte stream and strips framing/escape bytes.
- Emits Avalon-ST packet beats carrying SOP/EOP/channel sideband to the packet-to-transaction stage.
- Single output register stage, so downstream backpressure is absorbed one beat deep.

Parameters:
- CHANNEL_W, 8: width of out_channel; the channel byte is truncated to its low CHANNEL_W bits.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_valid  output  1  packet beat valid.
- out_data  output  8  decoded payload byte.
- out_startofpacket  output  1  first beat of packet.
- out_endofpacket  output  1  last beat of packet.
- out_channel  output  CHANNEL_W  channel of the current beat.
- out_ready  input  1  downstream ready.
- err_sticky  output  1  protocol error flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, err_sticky=0, all pending flags clear, in_ready=1 from the first cycle after reset. Reset mid-packet discards the partial packet and any held beat.
- Ready: in_ready = out_ready || !out_valid (combinational). Output register loads on accept of a data byte. out_valid clears when out_ready=1 and no new data byte is accepted that cycle.
- Latency: data byte accepted in cycle N → out_valid=1 in cycle N+1. Framing bytes produce no beat.
- Special bytes (unescaped):
  - 0x7A sets sop_pend.
  - 0x7B sets eop_pend.
  - 0x7C sets chan_pend.
  - 0x7D sets esc_pend.
- Escape: when esc_pend=1, the next byte is always data or channel, and its value is the byte XOR 0x20. esc_pend then clears.
- Channel: when chan_pend=1, the next non-escape byte (after un-escaping) loads the channel register, low CHANNEL_W bits. The byte is not emitted; chan_pend clears. 0x7C followed by 0x7D then 0x5C yields channel 0x7C.
- Data beat: out_data = decoded byte, out_startofpacket = sop_pend, out_endofpacket = eop_pend, out_channel = channel register. Both sop_pend and eop_pend clear on the beat.
- Single-beat packet: 0x7A 0x7B D → one beat with SOP=EOP=1.
- Repeated 0x7A or 0x7B before data is idempotent.
- Held beat: output is stable while out_valid && !out_ready. in_ready=0, so an upstream byte presented that cycle is not accepted.
- Pending flags are state (FSM IDLE/ESC/CHAN/CHAN_ESC plus sop/eop bits). A framing byte does not need the output register, so it may be accepted only when in_ready=1; in_ready gates all accepts uniformly.

Optional Feature:
- Macro QSYS_B2P_ERR_CHECK_EN.
- Defined: track an in_packet bit (set on a beat with SOP, cleared on a beat with EOP). err_sticky is set, and stays set until reset, on any of:
  - a data beat while !in_packet and without SOP;
  - a beat with SOP while in_packet;
  - 0x7D immediately followed by 0x7A–0x7D raw.
  Beats are still emitted unchanged.
- Not defined: err_sticky tied 0 and no tracking logic.

Decomposition:
- Package qsys_led_b2p_pkg holds:
  - localparams SOP_CHAR=8'h7A, EOP_CHAR=8'h7B, CHAN_CHAR=8'h7C, ESC_CHAR=8'h7D, ESC_XOR=8'h20;
  - the decoder state enum.
- One sub-module, qsys_led_b2p_oreg: the one-deep output register and ready logic, parameterised on payload width.

Test Plan:
- Stream 7A 7C 03 41 42 7B 43 with out_ready=1 → three beats: 0x41 (SOP=1, ch=3), 0x42, 0x43 (EOP=1, ch=3); each beat appears one cycle after its byte.
- 7A 7B 7D 5A → one beat, data 0x7A, SOP=EOP=1.
- 7C 7D 5C 7A 55 7B 66 → channel 0x7C; beats 0x55 (SOP) and 0x66 (EOP), both ch=0x7C.
- out_ready=0 for 3 cycles after a beat → out_* stable, in_ready=0, no byte lost; normal flow resumes when ready returns.
- Reset asserted after 7A 7D → next byte 0x7B is treated as EOP framing, not data 0x5B; all outputs are 0 during reset.
- With QSYS_B2P_ERR_CHECK_EN: 41 sent with no prior 7A → beat 0x41 emitted, err_sticky=1 and held until reset. Without the macro, err_sticky stays 0.
